sdr_arb: RTL and testbench
==========================

Name: sdr_arb

Overview:
SDRAM command-bus arbiter/scheduler that sits above the init, auto-refresh, write and read engines (sdr_init, sdr_ref, sdr_wr, sdr_rd).
- Holds the device in init until the init engine finishes.
- Runs the periodic refresh timer.
- Grants the shared command bus to exactly one engine at a time, using single-cycle request pulses and exit handshakes.
- Muxes the granted engine's command bundle onto the SDRAM pins.
- Priority: refresh > write/read; write and read alternate round-robin when both are pending.

Parameters:
REF_CYC, 1300, clocks between refresh requests (7.8 us at 167 MHz)
REF_CNT_W, 11, width of refresh timer counter; must satisfy 2^REF_CNT_W > REF_CYC

Ports:
clk  in  1  clock, 167 MHz
rst_n  in  1  asynchronous active-low reset
init_done  in  1  level; init engine finished, stays high
init_cmd  in  18  init engine bundle {nRAS,nCAS,nWE,BA[1:0],A[12:0]}
ref_cmd  in  18  refresh engine bundle
wr_cmd  in  18  write engine bundle
rd_cmd  in  18  read engine bundle
ref_exit  in  1  pulse; refresh engine done
wr_exit  in  1  pulse; write engine done (after final precharge)
rd_exit  in  1  pulse; read engine done
host_wr_req  in  1  level; host write pending
host_rd_req  in  1  level; host read pending
host_wr_ack  out  1  pulse; write accepted; host drops req next cycle
host_rd_ack  out  1  pulse; read accepted
sdr_ref_req  out  1  pulse; start refresh engine
sdr_wr_req  out  1  pulse; start write engine
sdr_rd_req  out  1  pulse; start read engine
sdr_grant  out  3  current state encoding
sdr_cmd  out  18  muxed command bundle to pins
ref_overrun  out  1  sticky error; refresh deadline missed

Behaviour:
- Reset values:
  - state = S_INIT.
  - All pulses 0, ref_overrun 0, last_wr 0.
  - Refresh timer 0, ref_pending 0.
  - sdr_grant = S_INIT.
- States are S_INIT, S_IDLE, S_REF, S_WR, S_RD, encoded 3'd0..3'd4.
- Transitions:
  - S_INIT -> S_IDLE when init_done=1.
  - S_IDLE, evaluated in this order:
    - ref_pending -> S_REF;
    - host_wr_req & host_rd_req -> S_RD if last_wr=1, else S_WR;
    - host_wr_req -> S_WR;
    - host_rd_req -> S_RD.
  - S_REF -> S_IDLE on ref_exit.
  - S_WR -> S_IDLE on wr_exit.
  - S_RD -> S_IDLE on rd_exit.
  - Other states are unreachable; default returns to S_IDLE.
- Every grant returns through S_IDLE, which gives at least one NOP cycle between engines.
- An exit pulse arriving in a non-matching state is ignored.
- Request pulses are registered and set on the same edge as the state change:
  - Host request seen in S_IDLE at cycle N -> state S_WR at N+1, with sdr_wr_req=1 and host_wr_ack=1 at N+1 only.
  - Same timing for sdr_ref_req (no host ack) and for rd.
- last_wr is set on entry to S_WR and cleared on entry to S_RD.
- Refresh timer:
  - Held at 0 until init_done.
  - Then counts 0..REF_CYC-1 and wraps, free-running and independent of grants.
  - At count REF_CYC-1, ref_pending is set.
  - If ref_pending is already 1 at that point, ref_overrun is set sticky until reset.
  - ref_pending is cleared on the S_IDLE->S_REF transition.
  - Set and clear in the same cycle: set wins, and ref_overrun is not raised.
- Refresh never preempts an active write or read; it waits for the exit and is taken at the next S_IDLE.
- sdr_cmd is a combinational mux on registered state:
  - S_INIT -> init_cmd;
  - S_REF -> ref_cmd;
  - S_WR -> wr_cmd;
  - S_RD -> rd_cmd;
  - S_IDLE/default -> NOP {3'b111, 2'b00, 13'h0}.
- sdr_grant equals the state register.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Engines are reset by the same rst_n.
- Re-initialisation is required after reset; the arbiter waits in S_INIT for init_done again.

Decomposition:
- Add to sdr_parameters.vh:
  - state encodings S_INIT..S_RD;
  - CMD_NOP bundle constant;
  - REF_CYC default (derived from tREFI/tCK).
- Sub-module sdr_ref_timer:
  - inputs: clk, rst_n, enable (init_done), clear (refresh grant);
  - outputs: ref_pending, ref_overrun.
- Arbiter FSM, pulse generation and command mux stay in sdr_arb.

Test Plan:
1. init_done held 0 for 50 cycles with host_wr_req=1 -> state stays S_INIT, sdr_cmd==init_cmd, no sdr_wr_req. Raise init_done -> S_IDLE next cycle, sdr_wr_req pulse one cycle later.
2. REF_CYC=16, no host traffic -> sdr_ref_req pulses; drive ref_exit 3 cycles after each pulse -> pulses exactly 16 cycles apart, ref_overrun stays 0.
3. host_wr_req and host_rd_req both held, with exits 5 cycles after each grant -> grants alternate WR, RD, WR, RD. Each ack is exactly one cycle wide. sdr_cmd is NOP on every S_IDLE cycle between grants.
4. REF_CYC=16; refresh becomes due during S_WR, with wr_exit delayed 10 cycles -> no sdr_ref_req until S_IDLE. S_REF is chosen ahead of a pending host_rd_req.
5. REF_CYC=16; wr_exit delayed 40 cycles -> ref_overrun rises at the second deadline and stays 1 after the refresh and subsequent traffic.
6. rst_n asserted mid-S_RD -> state=S_INIT, all pulses 0, sdr_cmd==init_cmd, timer 0, ref_overrun 0. A stray rd_exit after release is ignored.

Source files
------------

// File: rtl/sdr_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdr_arb_pkg
// Shared definitions for the SDRAM command-bus arbiter:
//   - arb_state_t : arbiter state encoding, also driven out as sdr_grant
//   - CMD_NOP     : {nRAS,nCAS,nWE,BA[1:0],A[12:0]} bundle for a NOP cycle
//   - REF_CYC_DEFAULT : refresh interval in clocks, derived from tREFI / tCK
// ---------------------------------------------------------------------------
package sdr_arb_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_REF  = 3'd2,
        S_WR   = 3'd3,
        S_RD   = 3'd4
    } arb_state_t;

    localparam int CMD_W = 18;

    localparam logic [CMD_W-1:0] CMD_NOP = {3'b111, 2'b00, 13'h0};

    // 7.8 us average refresh interval at a 6 ns (167 MHz) clock.
    localparam int TREFI_PS        = 7_800_000;
    localparam int TCK_PS          = 6_000;
    localparam int REF_CYC_DEFAULT = TREFI_PS / TCK_PS;

endpackage

// File: rtl/sdr_arb_ref_timer.sv
// ---------------------------------------------------------------------------
// sdr_arb_ref_timer
// Free-running refresh interval timer with a pending flag and sticky overrun.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : counting allowed (init finished); counter held at 0 when low
//   clear         : refresh granted this cycle; drops ref_pending
//   ref_pending   : a refresh is owed to the device
//   ref_overrun   : sticky; a new deadline arrived while one was still owed
// ---------------------------------------------------------------------------
module sdr_arb_ref_timer #(
    parameter int REF_CYC   = 1300,
    parameter int REF_CNT_W = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic ref_pending,
    output logic ref_overrun
);

    logic [REF_CNT_W-1:0] r_cnt;
    logic                 r_pending;
    logic                 r_overrun;
    logic                 w_wrap;

    assign w_wrap = enable && (r_cnt == REF_CNT_W'(REF_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (!enable || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // A new deadline wins over a simultaneous grant.
            if (w_wrap) begin
                r_pending <= 1'b1;
            end else if (clear) begin
                r_pending <= 1'b0;
            end

            // Overrun only when the previous refresh is still owed and is
            // not being granted on this very edge.
            if (w_wrap && r_pending && !clear) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign ref_pending = r_pending;
    assign ref_overrun = r_overrun;

endmodule

// File: rtl/sdr_arb.sv
// ---------------------------------------------------------------------------
// sdr_arb
// SDRAM command-bus arbiter. Holds the bus in init until init_done, then
// grants it to one engine at a time (refresh > write/read, write and read
// alternating when both wait) and muxes that engine's command onto the pins.
// Every grant returns through S_IDLE, which always drives a NOP.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   init_done                  : init engine finished (level)
//   init/ref/wr/rd_cmd [17:0]  : engine command bundles
//   ref/wr/rd_exit             : engine done pulses
//   host_wr_req, host_rd_req   : host requests (level)
//   host_wr_ack, host_rd_ack   : one-cycle accept pulses to the host
//   sdr_ref/wr/rd_req          : one-cycle engine start pulses
//   sdr_grant [2:0]            : current arbiter state
//   sdr_cmd [17:0]             : command bundle to SDRAM pins
//   ref_overrun                : sticky missed-refresh error
// ---------------------------------------------------------------------------
module sdr_arb
    import sdr_arb_pkg::*;
#(
    parameter int REF_CYC   = REF_CYC_DEFAULT,
    parameter int REF_CNT_W = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic [17:0] init_cmd,
    input  logic [17:0] ref_cmd,
    input  logic [17:0] wr_cmd,
    input  logic [17:0] rd_cmd,
    input  logic        ref_exit,
    input  logic        wr_exit,
    input  logic        rd_exit,
    input  logic        host_wr_req,
    input  logic        host_rd_req,
    output logic        host_wr_ack,
    output logic        host_rd_ack,
    output logic        sdr_ref_req,
    output logic        sdr_wr_req,
    output logic        sdr_rd_req,
    output logic [2:0]  sdr_grant,
    output logic [17:0] sdr_cmd,
    output logic        ref_overrun
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_ref_req;
    logic       r_wr_req;
    logic       r_rd_req;
    logic       r_last_wr;
    logic       w_ref_pending;
    logic       w_take_ref;
    logic       w_take_wr;
    logic       w_take_rd;

    sdr_arb_ref_timer #(
        .REF_CYC   (REF_CYC),
        .REF_CNT_W (REF_CNT_W)
    ) u_ref_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (init_done),
        .clear       (w_take_ref),
        .ref_pending (w_ref_pending),
        .ref_overrun (ref_overrun)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: if (init_done) w_next = S_IDLE;
            S_IDLE: begin
                if (w_ref_pending) begin
                    w_next = S_REF;
                end else if (host_wr_req && host_rd_req) begin
                    // Alternate: whichever direction did not go last.
                    w_next = r_last_wr ? S_RD : S_WR;
                end else if (host_wr_req) begin
                    w_next = S_WR;
                end else if (host_rd_req) begin
                    w_next = S_RD;
                end
            end
            S_REF:   if (ref_exit) w_next = S_IDLE;
            S_WR:    if (wr_exit)  w_next = S_IDLE;
            S_RD:    if (rd_exit)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_take_ref = (r_state == S_IDLE) && (w_next == S_REF);
    assign w_take_wr  = (r_state == S_IDLE) && (w_next == S_WR);
    assign w_take_rd  = (r_state == S_IDLE) && (w_next == S_RD);

    // Start pulses are registered so they line up with the new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_INIT;
            r_ref_req <= 1'b0;
            r_wr_req  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_last_wr <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ref_req <= w_take_ref;
            r_wr_req  <= w_take_wr;
            r_rd_req  <= w_take_rd;
            if (w_take_wr) begin
                r_last_wr <= 1'b1;
            end else if (w_take_rd) begin
                r_last_wr <= 1'b0;
            end
        end
    end

    always_comb begin
        sdr_cmd = CMD_NOP;
        case (r_state)
            S_INIT:  sdr_cmd = init_cmd;
            S_REF:   sdr_cmd = ref_cmd;
            S_WR:    sdr_cmd = wr_cmd;
            S_RD:    sdr_cmd = rd_cmd;
            default: sdr_cmd = CMD_NOP;
        endcase
    end

    assign sdr_grant   = r_state;
    assign sdr_ref_req = r_ref_req;
    assign sdr_wr_req  = r_wr_req;
    assign sdr_rd_req  = r_rd_req;
    assign host_wr_ack = r_wr_req;
    assign host_rd_ack = r_rd_req;

endmodule

// File: tb/tb_sdr_arb.sv
// ---------------------------------------------------------------------------
// tb_sdr_arb
// Directed bench for sdr_arb with REF_CYC = 16. Stimulus pushes the expected
// sequence of engine start pulses (kind and spacing in clocks) into a queue;
// a monitor pops one entry per pulse it sees. Engine responders return the
// exit pulse a programmable number of cycles after each start pulse, and a
// host agent drops its request once it has been acknowledged.
// ---------------------------------------------------------------------------
module tb_sdr_arb;
    import sdr_arb_pkg::*;

    localparam int TB_REF_CYC = 16;
    localparam logic [17:0] INIT_CMD = 18'h1_0001;
    localparam logic [17:0] REF_CMD  = 18'h0_4002;
    localparam logic [17:0] WR_CMD   = 18'h0_C003;
    localparam logic [17:0] RD_CMD   = 18'h1_4004;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic        ref_exit, wr_exit, rd_exit;
    logic        host_wr_req, host_rd_req;
    logic        host_wr_ack, host_rd_ack;
    logic        sdr_ref_req, sdr_wr_req, sdr_rd_req;
    logic [2:0]  sdr_grant;
    logic [17:0] sdr_cmd;
    logic        ref_overrun;

    typedef struct {
        int kind;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   ref_dly, wr_dly, rd_dly;
    int   wr_issued, rd_issued;
    int   wr_acked = 0;
    int   rd_acked = 0;

    sdr_arb #(
        .REF_CYC   (TB_REF_CYC),
        .REF_CNT_W (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .init_cmd    (INIT_CMD),
        .ref_cmd     (REF_CMD),
        .wr_cmd      (WR_CMD),
        .rd_cmd      (RD_CMD),
        .ref_exit    (ref_exit),
        .wr_exit     (wr_exit),
        .rd_exit     (rd_exit),
        .host_wr_req (host_wr_req),
        .host_rd_req (host_rd_req),
        .host_wr_ack (host_wr_ack),
        .host_rd_ack (host_rd_ack),
        .sdr_ref_req (sdr_ref_req),
        .sdr_wr_req  (sdr_wr_req),
        .sdr_rd_req  (sdr_rd_req),
        .sdr_grant   (sdr_grant),
        .sdr_cmd     (sdr_cmd),
        .ref_overrun (ref_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000 ns");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k, input int g);
        exp_t e;
        e.kind = k;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() > 0; i++) step();
        chk("expected_pulses_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        init_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Engine responders: exit is sampled dly clocks after the start pulse.
    initial begin
        ref_exit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sdr_ref_req) begin
                repeat (ref_dly - 1) @(posedge clk);
                #1 ref_exit = 1'b1;
                @(posedge clk);
                #1 ref_exit = 1'b0;
            end
        end
    end

    initial begin
        wr_exit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sdr_wr_req) begin
                repeat (wr_dly - 1) @(posedge clk);
                #1 wr_exit = 1'b1;
                @(posedge clk);
                #1 wr_exit = 1'b0;
            end
        end
    end

    initial begin
        rd_exit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sdr_rd_req) begin
                repeat (rd_dly - 1) @(posedge clk);
                #1 rd_exit = 1'b1;
                @(posedge clk);
                #1 rd_exit = 1'b0;
            end
        end
    end

    // Host agent: request stays up while issued transfers are unacknowledged.
    initial begin
        host_wr_req = 1'b0;
        host_rd_req = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (host_wr_ack) wr_acked++;
            if (host_rd_ack) rd_acked++;
            host_wr_req = (wr_issued > wr_acked);
            host_rd_req = (rd_issued > rd_acked);
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [2:0] pulses;
        logic [2:0] prev_pulses;
        int         last_cyc;
        int         kind;
        exp_t       e;
        prev_pulses = 3'b000;
        last_cyc    = 0;
        forever begin
            @(negedge clk);
            pulses = {sdr_ref_req, sdr_wr_req, sdr_rd_req};
            if (rst_n) begin
                if (sdr_grant == 3'(S_IDLE)) chk("idle_cmd_nop", int'(sdr_cmd), int'(CMD_NOP));
                if (sdr_grant == 3'(S_WR))   chk("wr_cmd_mux", int'(sdr_cmd), int'(WR_CMD));
                if (sdr_grant == 3'(S_RD))   chk("rd_cmd_mux", int'(sdr_cmd), int'(RD_CMD));
                if (sdr_grant == 3'(S_REF))  chk("ref_cmd_mux", int'(sdr_cmd), int'(REF_CMD));
                if ((pulses & prev_pulses) != 3'b000)
                    chk("pulse_width_one", int'(pulses & prev_pulses), 0);
                if (pulses != 3'b000) begin
                    chk("pulse_onehot", $countones(pulses), 1);
                    kind = sdr_ref_req ? int'(S_REF) : sdr_wr_req ? int'(S_WR) : int'(S_RD);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse_kind", kind, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_kind", kind, e.kind);
                        chk("host_wr_ack", int'(host_wr_ack), int'(e.kind == int'(S_WR)));
                        chk("host_rd_ack", int'(host_rd_ack), int'(e.kind == int'(S_RD)));
                        if (e.gap >= 0) chk("pulse_gap", cyc - last_cyc, e.gap);
                    end
                    last_cyc = cyc;
                end else if (host_wr_ack || host_rd_ack) begin
                    chk("stray_ack", int'({host_wr_ack, host_rd_ack}), 0);
                end
            end
            prev_pulses = rst_n ? pulses : 3'b000;
        end
    end

    initial begin
        rst_n     = 1'b0;
        init_done = 1'b0;
        ref_dly   = 3;
        wr_dly    = 3;
        rd_dly    = 3;
        wr_issued = 0;
        rd_issued = 0;

        // 1: held in init; then first write one cycle after S_IDLE.
        do_reset();
        chk("rst_grant", int'(sdr_grant), int'(S_INIT));
        chk("rst_cmd", int'(sdr_cmd), int'(INIT_CMD));
        chk("rst_pulses", int'({sdr_ref_req, sdr_wr_req, sdr_rd_req, host_wr_ack, host_rd_ack}), 0);
        chk("rst_overrun", int'(ref_overrun), 0);
        wr_issued = wr_issued + 1;
        repeat (50) step();
        chk("init_hold_grant", int'(sdr_grant), int'(S_INIT));
        chk("init_hold_cmd", int'(sdr_cmd), int'(INIT_CMD));
        push_exp(int'(S_WR), -1);
        push_exp(int'(S_REF), 15);
        init_done = 1'b1;
        step();
        chk("init_to_idle", int'(sdr_grant), int'(S_IDLE));
        step();
        chk("idle_to_wr", int'(sdr_grant), int'(S_WR));
        wait_empty(40);
        repeat (4) step();

        // 2: periodic refresh with no host traffic.
        do_reset();
        push_exp(int'(S_REF), -1);
        push_exp(int'(S_REF), 16);
        push_exp(int'(S_REF), 16);
        init_done = 1'b1;
        step();
        wait_empty(70);
        chk("periodic_no_overrun", int'(ref_overrun), 0);
        repeat (4) step();

        // 3: write/read alternation, refresh slotted in at the next idle.
        do_reset();
        wr_dly    = 5;
        rd_dly    = 5;
        wr_issued = wr_issued + 2;
        rd_issued = rd_issued + 2;
        push_exp(int'(S_WR), -1);
        push_exp(int'(S_RD), 6);
        push_exp(int'(S_WR), 6);
        push_exp(int'(S_REF), 6);
        push_exp(int'(S_RD), 4);
        push_exp(int'(S_REF), 9);
        init_done = 1'b1;
        step();
        wait_empty(60);
        chk("alternate_no_overrun", int'(ref_overrun), 0);
        repeat (4) step();

        // 4: refresh due during a long write waits, then beats a pending read.
        do_reset();
        wr_dly = 10;
        rd_dly = 3;
        push_exp(int'(S_WR), -1);
        push_exp(int'(S_REF), 11);
        push_exp(int'(S_RD), 4);
        init_done = 1'b1;
        step();
        repeat (9) step();
        wr_issued = wr_issued + 1;
        rd_issued = rd_issued + 1;
        step();
        repeat (6) step();
        chk("no_preempt_grant", int'(sdr_grant), int'(S_WR));
        chk("no_preempt_ref_req", int'(sdr_ref_req), 0);
        wait_empty(40);
        chk("deferred_no_overrun", int'(ref_overrun), 0);
        repeat (4) step();

        // 5: write held past two deadlines raises a sticky overrun.
        do_reset();
        wr_dly    = 40;
        rd_dly    = 3;
        wr_issued = wr_issued + 1;
        push_exp(int'(S_WR), -1);
        push_exp(int'(S_REF), 41);
        push_exp(int'(S_RD), 4);
        push_exp(int'(S_REF), 4);
        init_done = 1'b1;
        step();
        repeat (30) step();
        chk("overrun_before_2nd", int'(ref_overrun), 0);
        step();
        chk("overrun_at_2nd", int'(ref_overrun), 1);
        rd_issued = rd_issued + 1;
        wait_empty(60);
        chk("overrun_sticky", int'(ref_overrun), 1);
        repeat (4) step();

        // 6: asynchronous reset mid-read; stray exit afterwards is ignored.
        do_reset();
        chk("rst_clears_overrun", int'(ref_overrun), 0);
        rd_dly    = 8;
        ref_dly   = 3;
        rd_issued = rd_issued + 1;
        push_exp(int'(S_RD), -1);
        init_done = 1'b1;
        step();
        step();
        chk("pre_reset_rd", int'(sdr_grant), int'(S_RD));
        step();
        step();
        rst_n     = 1'b0;
        init_done = 1'b0;
        #1;
        chk("async_rst_grant", int'(sdr_grant), int'(S_INIT));
        chk("async_rst_cmd", int'(sdr_cmd), int'(INIT_CMD));
        chk("async_rst_pulses", int'({sdr_ref_req, sdr_wr_req, sdr_rd_req, host_wr_ack, host_rd_ack}), 0);
        chk("async_rst_overrun", int'(ref_overrun), 0);
        step();
        step();
        rst_n     = 1'b1;
        init_done = 1'b1;
        // Timer restarted from 0: refresh 16 cycles after re-init.
        push_exp(int'(S_REF), 21);
        step();
        chk("reinit_idle", int'(sdr_grant), int'(S_IDLE));
        repeat (4) step();
        chk("stray_exit_ignored", int'(sdr_grant), int'(S_IDLE));
        wait_empty(40);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
